// File: rtl/pwm_duty_modulator.sv
// Complementary PWM pair with dead-time, driven by a duty word that is
// double-buffered at each PWM period boundary.
module pwm_duty_modulator #(
  parameter int PERIOD   = 64,
  parameter int DUTY_W   = 7,
  parameter int DEADTIME = 2
) (
  input  logic              sysclk,
  input  logic              Reset_n,
  input  logic              Enable_SW_0,
  input  logic [DUTY_W-1:0] Duty_Input,
  output logic              PWM_Out,
  output logic              PWM_Out_N,
  output logic              Period_Start,
  output logic [DUTY_W-1:0] Duty_Active,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int DT_W  = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;

  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(PERIOD - 1);
  localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(PERIOD);
  localparam logic [DT_W-1:0]   DT_LOAD  = DT_W'(DEADTIME);

  typedef enum logic [1:0] {
    LOW_ON    = 2'd0,
    DEAD_RISE = 2'd1,
    HIGH_ON   = 2'd2,
    DEAD_FALL = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DT_W-1:0]   dead_q, dead_d;
  logic [DUTY_W-1:0] duty_active_q, duty_active_d;
  logic              period_start_q, period_start_d;
  logic              period_end;
  logic              raw;
  logic              dead_exit;

  // Period counter and shadow duty register; inputs only matter at the wrap edge.
  always_comb begin
    period_end     = (cnt_q == CNT_MAX);
    cnt_d          = period_end ? '0 : cnt_q + CNT_W'(1);
    period_start_d = period_end;
    duty_active_d  = duty_active_q;
    if (period_end) begin
      if (!Enable_SW_0) begin
        duty_active_d = '0;
      end else if (Duty_Input > DUTY_MAX) begin
        duty_active_d = DUTY_MAX;
      end else begin
        duty_active_d = Duty_Input;
      end
    end
  end

  assign raw = (DUTY_W'(cnt_q) < duty_active_q);

  // Dead counter reading 0 only happens with DEADTIME=0, so treat it as expired too.
  assign dead_exit = (dead_q <= DT_W'(1));

  always_comb begin
    state_d = state_q;
    dead_d  = dead_q;
    case (state_q)
      LOW_ON: begin
        if (raw) begin
          if (DEADTIME == 0) begin
            state_d = HIGH_ON;
          end else begin
            state_d = DEAD_RISE;
            dead_d  = DT_LOAD;
          end
        end
      end
      HIGH_ON: begin
        if (!raw) begin
          if (DEADTIME == 0) begin
            state_d = LOW_ON;
          end else begin
            state_d = DEAD_FALL;
            dead_d  = DT_LOAD;
          end
        end
      end
      DEAD_RISE, DEAD_FALL: begin
        if (dead_exit) begin
          state_d = raw ? HIGH_ON : LOW_ON;
        end else begin
          dead_d = dead_q - DT_W'(1);
        end
      end
      default: begin
        state_d = DEAD_FALL;
        dead_d  = DT_LOAD;
      end
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!Reset_n) begin
      cnt_q          <= '0;
      duty_active_q  <= '0;
      period_start_q <= 1'b0;
      state_q        <= DEAD_FALL;
      dead_q         <= DT_LOAD;
    end else begin
      cnt_q          <= cnt_d;
      duty_active_q  <= duty_active_d;
      period_start_q <= period_start_d;
      state_q        <= state_d;
      dead_q         <= dead_d;
    end
  end

  assign PWM_Out      = (state_q == HIGH_ON);
  assign PWM_Out_N    = (state_q == LOW_ON);
  assign Period_Start = period_start_q;
  assign Duty_Active  = duty_active_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_pwm_duty_modulator.sv
// Bench for pwm_duty_modulator: directed vector table, hand-written corner
// sequences and a long randomized run against a timeline-based reference model.
module tb_pwm_duty_modulator;

  localparam int P  = 64;
  localparam int W  = 7;
  localparam int DT = 2;

  logic         sysclk = 1'b0;
  logic         Reset_n = 1'b0;
  logic         Enable_SW_0 = 1'b0;
  logic [W-1:0] Duty_Input = '0;
  logic         PWM_Out;
  logic         PWM_Out_N;
  logic         Period_Start;
  logic [W-1:0] Duty_Active;
  logic [1:0]   dbg_state;

  pwm_duty_modulator #(.PERIOD(P), .DUTY_W(W), .DEADTIME(DT)) dut (
    .sysclk      (sysclk),
    .Reset_n     (Reset_n),
    .Enable_SW_0 (Enable_SW_0),
    .Duty_Input  (Duty_Input),
    .PWM_Out     (PWM_Out),
    .PWM_Out_N   (PWM_Out_N),
    .Period_Start(Period_Start),
    .Duty_Active (Duty_Active),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 sysclk = ~sysclk;

  // ---------------- bookkeeping ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  int t      = 0;   // absolute cycle index, advanced once per edge
  int rel0   = 0;   // t of the first cycle after the last reset release
  int last_ps = -1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at t=%0d (rel %0d): got %0d expected %0d", name, t, t - rel0, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Gate behaviour described as a timeline: any change of the wanted side
  // blanks both gates until absolute cycle m_resume, after which the side
  // wanted at that moment is driven.
  int m_phase  = 0;
  int m_duty   = 0;
  bit m_ps     = 0;
  bit m_side   = 0;
  int m_resume = 0;

  function automatic int sat_duty(input int d, input bit en);
    if (!en) return 0;
    return (d > P) ? P : d;
  endfunction

  task automatic model_step();
    int tn;
    bit raw;
    tn  = t + 1;
    raw = (m_phase < m_duty);
    if (!Reset_n) begin
      m_phase  = 0;
      m_duty   = 0;
      m_ps     = 0;
      m_resume = tn + DT;
    end else begin
      if (t < m_resume) begin
        if (tn == m_resume) m_side = raw;
      end else if (raw != m_side) begin
        if (DT == 0) m_side = raw;
        else m_resume = tn + DT;
      end
      m_ps = (m_phase == P - 1);
      if (m_ps) m_duty = sat_duty(int'(Duty_Input), Enable_SW_0);
      m_phase = (m_phase + 1) % P;
    end
  endtask

  task automatic compare_model();
    bit on;
    on = (t >= m_resume);
    check("pwm_out",      int'(PWM_Out),      int'(on && m_side));
    check("pwm_out_n",    int'(PWM_Out_N),    int'(on && !m_side));
    check("period_start", int'(Period_Start), int'(m_ps));
    check("duty_active",  int'(Duty_Active),  m_duty);
    check("gate_overlap", int'(PWM_Out & PWM_Out_N), 0);
    if (!Reset_n) begin
      last_ps = -1;
    end else if (Period_Start) begin
      if (last_ps >= 0) check("ps_spacing", t - last_ps, P);
      last_ps = t;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_step();
    @(posedge sysclk);
    #1;
    t++;
    compare_model();
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    tick();
    tick();
    Reset_n = 1'b1;
    rel0 = t;
  endtask

  task automatic run_to(input int rel);
    while (t - rel0 < rel) tick();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int cyc;
    bit pwm;
    bit pwm_n;
    bit ps;
    int duty;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int bad;

    vecs[0]  = '{0,   0, 0, 0, 0};
    vecs[1]  = '{1,   0, 0, 0, 0};
    vecs[2]  = '{2,   0, 1, 0, 0};
    vecs[3]  = '{63,  0, 1, 0, 0};
    vecs[4]  = '{64,  0, 1, 1, 32};
    vecs[5]  = '{65,  0, 0, 0, 32};
    vecs[6]  = '{66,  0, 0, 0, 32};
    vecs[7]  = '{67,  1, 0, 0, 32};
    vecs[8]  = '{80,  1, 0, 0, 32};
    vecs[9]  = '{96,  1, 0, 0, 32};
    vecs[10] = '{97,  0, 0, 0, 32};
    vecs[11] = '{98,  0, 0, 0, 32};
    vecs[12] = '{99,  0, 1, 0, 32};
    vecs[13] = '{127, 0, 1, 0, 32};
    vecs[14] = '{128, 0, 1, 1, 32};
    vecs[15] = '{131, 1, 0, 0, 32};

    // Duty 32 from release: exact edge positions of the first two periods.
    Duty_Input  = 7'd32;
    Enable_SW_0 = 1'b1;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      run_to(vecs[i].cyc);
      check($sformatf("vec%0d_pwm", i),   int'(PWM_Out),      int'(vecs[i].pwm));
      check($sformatf("vec%0d_pwm_n", i), int'(PWM_Out_N),    int'(vecs[i].pwm_n));
      check($sformatf("vec%0d_ps", i),    int'(Period_Start), int'(vecs[i].ps));
      check($sformatf("vec%0d_duty", i),  int'(Duty_Active),  vecs[i].duty);
    end

    // Full duty: no dead band at wraps; then 100 saturates to the same waveform.
    Duty_Input = 7'd64;
    do_reset();
    run_to(70);
    Duty_Input = 7'd100;
    bad = 0;
    while (t - rel0 < 260) begin
      tick();
      if (!(PWM_Out && !PWM_Out_N)) bad++;
    end
    check("full_duty_low_cycles", bad, 0);
    check("saturated_duty", int'(Duty_Active), 64);

    // Duty 1 is shorter than the dead time: high side never fires.
    Duty_Input = 7'd1;
    do_reset();
    run_to(127);
    bad = 0;
    while (t - rel0 < 191) begin
      tick();
      if (PWM_Out) bad++;
      if (PWM_Out_N != !((t - rel0 == 129) || (t - rel0 == 130))) bad++;
    end
    check("tiny_duty_pattern_errors", bad, 0);

    // Mid-period duty change is deferred to the next period.
    Duty_Input = 7'd10;
    do_reset();
    run_to(84);
    Duty_Input = 7'd50;
    run_to(127);
    check("deferred_old_duty", int'(Duty_Active), 10);
    run_to(128);
    check("deferred_new_duty", int'(Duty_Active), 50);
    check("deferred_new_ps", int'(Period_Start), 1);

    // Enable dropped mid-period: current period finishes at 40, then idle low.
    Duty_Input = 7'd40;
    Enable_SW_0 = 1'b1;
    do_reset();
    run_to(74);
    Enable_SW_0 = 1'b0;
    run_to(100);
    check("enable_drop_still_high", int'(PWM_Out), 1);
    run_to(127);
    check("enable_drop_old_duty", int'(Duty_Active), 40);
    run_to(128);
    check("enable_drop_zero_duty", int'(Duty_Active), 0);
    bad = 0;
    while (t - rel0 < 200) begin
      tick();
      if (PWM_Out || !PWM_Out_N) bad++;
    end
    check("enable_drop_idle_errors", bad, 0);

    // Mid-period reset: both gates off in the very next cycle.
    Enable_SW_0 = 1'b1;
    Duty_Input  = 7'd64;
    do_reset();
    run_to(100);
    Reset_n = 1'b0;
    tick();
    check("reset_mid_pwm", int'(PWM_Out), 0);
    check("reset_mid_pwm_n", int'(PWM_Out_N), 0);
    check("reset_mid_duty", int'(Duty_Active), 0);
    Reset_n = 1'b1;
    rel0 = t;

    // Randomized run against the reference model.
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 3) == 0) Duty_Input = W'($urandom_range(0, 127));
        else Duty_Input = W'($urandom_range(0, 3) + (($urandom_range(0, 1) == 1) ? 62 : 0));
        if ($urandom_range(0, 3) == 0) Duty_Input = W'($urandom_range(0, 64));
      end
      if ($urandom_range(0, 39) == 0) Enable_SW_0 = ($urandom_range(0, 4) != 0);
      Reset_n = ($urandom_range(0, 1999) != 0);
      tick();
    end
    Reset_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
